// File: rtl/processor_arbiter.sv
// Round-robin arbiter between a data-path requester (A) and an instruction
// requester (B) sharing one processor. A winner's operand is registered onto
// the processor, held for 1 + CAPTURE_DLY cycles, and the processor result
// is then presented on a valid/ready response port.
module processor_arbiter #(
  parameter int CAPTURE_DLY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_req,
  input  logic [31:0] a_data,
  output logic        a_ack,
  input  logic        b_req,
  input  logic [31:0] b_data,
  output logic        b_ack,
  input  logic        cfg_we,
  input  logic [15:0] cfg_flags,
  output logic [31:0] proc_data_in,
  output logic [31:0] proc_i_data,
  output logic        proc_data_select,
  output logic [15:0] proc_status_flags,
  input  logic [31:0] proc_data_out,
  input  logic [7:0]  proc_status,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic [7:0]  resp_status,
  output logic        resp_src,
  output logic        busy,
  output logic [7:0]  a_count,
  output logic [7:0]  b_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [2:0]  r_dly;
  logic        r_last_grant;   // 0 = A granted last, 1 = B granted last
  logic        r_src;
  logic        r_a_ack;
  logic        r_b_ack;
  logic [31:0] r_data_in;
  logic [31:0] r_i_data;
  logic        r_select;
  logic [15:0] r_shadow;
  logic [15:0] r_flags;
  logic [31:0] r_resp_data;
  logic [7:0]  r_resp_status;
  logic        r_resp_src;
  logic [7:0]  r_a_count;
  logic [7:0]  r_b_count;

  logic w_grant_a;
  logic w_grant_b;
  logic w_drive_done;

  // A wins when alone, or when both request and B was granted last.
  assign w_grant_a    = a_req && (!b_req || r_last_grant);
  assign w_grant_b    = b_req && !w_grant_a;
  assign w_drive_done = (r_dly == 3'(CAPTURE_DLY));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state logic: IDLE -> DRIVE on any request, DRIVE -> RESP after the
  // capture delay, RESP -> IDLE on handshake.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (a_req || b_req) w_state_next = S_DRIVE;
      S_DRIVE: if (w_drive_done)   w_state_next = S_RESP;
      S_RESP:  if (resp_ready)     w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Datapath: grant registration, capture delay, response capture, counters
  // and the flag shadow. Flags only follow the shadow while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dly         <= '0;
      r_last_grant  <= 1'b1;
      r_src         <= 1'b0;
      r_a_ack       <= 1'b0;
      r_b_ack       <= 1'b0;
      r_data_in     <= '0;
      r_i_data      <= '0;
      r_select      <= 1'b0;
      r_shadow      <= '0;
      r_flags       <= '0;
      r_resp_data   <= '0;
      r_resp_status <= '0;
      r_resp_src    <= 1'b0;
      r_a_count     <= '0;
      r_b_count     <= '0;
    end else begin
      r_a_ack <= 1'b0;
      r_b_ack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_flags <= r_shadow;
          if (w_grant_a) begin
            r_a_ack      <= 1'b1;
            r_data_in    <= a_data;
            r_select     <= 1'b1;
            r_last_grant <= 1'b0;
            r_src        <= 1'b0;
            r_dly        <= '0;
          end else if (w_grant_b) begin
            r_b_ack      <= 1'b1;
            r_i_data     <= b_data;
            r_select     <= 1'b0;
            r_last_grant <= 1'b1;
            r_src        <= 1'b1;
            r_dly        <= '0;
          end
        end
        S_DRIVE: begin
          if (w_drive_done) begin
            r_resp_data   <= proc_data_out;
            r_resp_status <= proc_status;
            r_resp_src    <= r_src;
          end else begin
            r_dly <= r_dly + 3'd1;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            if (r_resp_src) r_b_count <= r_b_count + 8'd1;
            else            r_a_count <= r_a_count + 8'd1;
          end
        end
        default: ;
      endcase
      if (cfg_we) r_shadow <= cfg_flags;
    end
  end

  assign a_ack             = r_a_ack;
  assign b_ack             = r_b_ack;
  assign proc_data_in      = r_data_in;
  assign proc_i_data       = r_i_data;
  assign proc_data_select  = r_select;
  assign proc_status_flags = r_flags;
  assign resp_valid        = (r_state == S_RESP);
  assign resp_data         = r_resp_data;
  assign resp_status       = r_resp_status;
  assign resp_src          = r_resp_src;
  assign busy              = (r_state != S_IDLE);
  assign a_count           = r_a_count;
  assign b_count           = r_b_count;

endmodule
